// File: rtl/pipe_collide_score_if.sv
// Game-step bus between the bird/pipe front end and the collision/score block.
// Tick qualifies everything: inputs are sampled only on clk edges where Tick=1, and outputs reflect that step one clk later.
interface pipe_collide_score_if;
    logic        Tick;
    logic        Button;
    logic [15:0] PipesPosition;
    logic [15:0] PipesLong;
    logic [15:0] BirdY;
    logic        Status;
    logic        Hit;
    logic [15:0] Score;
    logic [15:0] BestScore;
    logic [1:0]  State;

    modport master (
        output Tick, Button, PipesPosition, PipesLong, BirdY,
        input  Status, Hit, Score, BestScore, State
    );

    modport slave (
        input  Tick, Button, PipesPosition, PipesLong, BirdY,
        output Status, Hit, Score, BestScore, State
    );
endinterface

// File: rtl/pipe_collide_score.sv
// Flappy-bird game controller: pipe/ground collision, BCD pass scoring and best-score tracking.
// All state advances only on Tick; Hit is a single-clk pulse on entry to DEAD.
module pipe_collide_score #(
    parameter int BIRD_X   = 200,
    parameter int BIRD_W   = 34,
    parameter int BIRD_H   = 24,
    parameter int PIPE_W   = 90,
    parameter int CAP_H    = 33,
    parameter int GAP      = 150,
    parameter int GROUND_Y = 428
) (
    input  logic                 clk,
    input  logic                 Reset,
    pipe_collide_score_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DEAD = 2'd2
    } state_t;

    // 17-bit geometry so pipe/bird sums never wrap
    localparam logic [16:0] L_BIRD_X   = 17'(BIRD_X);
    localparam logic [16:0] L_BIRD_R   = 17'(BIRD_X + BIRD_W - 1);
    localparam logic [16:0] L_REARM    = 17'(BIRD_X + BIRD_W);
    localparam logic [16:0] L_PIPE_W   = 17'(PIPE_W);
    localparam logic [16:0] L_CAP_H    = 17'(CAP_H);
    localparam logic [16:0] L_GAP      = 17'(GAP);
    localparam logic [16:0] L_BIRD_HM1 = 17'(BIRD_H - 1);
    localparam logic [16:0] L_GROUND   = 17'(GROUND_Y);

    state_t      r_state, w_state_nxt;
    logic [15:0] r_score, w_score_nxt;
    logic [15:0] r_best, w_best_nxt;
    logic        r_passed, w_passed_nxt;
    logic        r_hit, w_hit_nxt;

    logic [16:0] w_pos, w_pipe_r, w_bird_bot, w_top_lim, w_bot_lim;
    logic        w_overlap, w_collide, w_score_zone, w_rearm;

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] res;
        logic        carry;
        res   = v;
        carry = 1'b1;
        if (v != 16'h9999) begin
            for (int i = 0; i < 4; i++) begin
                if (carry) begin
                    if (res[i*4 +: 4] == 4'd9) begin
                        res[i*4 +: 4] = 4'd0;
                    end else begin
                        res[i*4 +: 4] = res[i*4 +: 4] + 4'd1;
                        carry         = 1'b0;
                    end
                end
            end
        end
        return res;
    endfunction

    assign w_pos        = {1'b0, bus.PipesPosition};
    assign w_pipe_r     = w_pos + L_PIPE_W;
    assign w_bird_bot   = {1'b0, bus.BirdY} + L_BIRD_HM1;
    assign w_top_lim    = {1'b0, bus.PipesLong} + L_CAP_H;
    assign w_bot_lim    = {1'b0, bus.PipesLong} + L_GAP;
    assign w_overlap    = (w_pos <= L_BIRD_R) && (w_pipe_r >= L_BIRD_X);
    assign w_collide    = (w_overlap && (({1'b0, bus.BirdY} <= w_top_lim) || (w_bird_bot >= w_bot_lim)))
                        || (w_bird_bot >= L_GROUND);
    assign w_score_zone = (w_pipe_r < L_BIRD_X);
    assign w_rearm      = (w_pos > L_REARM);

    always_comb begin
        w_state_nxt  = r_state;
        w_score_nxt  = r_score;
        w_best_nxt   = r_best;
        w_passed_nxt = r_passed;
        w_hit_nxt    = 1'b0;
        if (bus.Tick) begin
            case (r_state)
                S_IDLE: begin
                    if (!bus.Button) begin
                        w_state_nxt  = S_RUN;
                        w_score_nxt  = 16'h0000;
                        w_passed_nxt = 1'b0;
                    end
                end
                S_RUN: begin
                    // collision takes priority over a same-step pass
                    if (w_collide) begin
                        w_state_nxt = S_DEAD;
                        w_hit_nxt   = 1'b1;
                        if (r_score > r_best) w_best_nxt = r_score;
                    end else if (!r_passed && w_score_zone) begin
                        w_score_nxt  = bcd_inc(r_score);
                        w_passed_nxt = 1'b1;
                    end else if (w_rearm) begin
                        w_passed_nxt = 1'b0;
                    end
                end
                S_DEAD: begin
                    if (bus.Button) w_state_nxt = S_IDLE;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_state  <= S_IDLE;
            r_score  <= 16'h0000;
            r_best   <= 16'h0000;
            r_passed <= 1'b0;
            r_hit    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_score  <= w_score_nxt;
            r_best   <= w_best_nxt;
            r_passed <= w_passed_nxt;
            r_hit    <= w_hit_nxt;
        end
    end

    assign bus.State     = r_state;
    assign bus.Status    = (r_state == S_RUN);
    assign bus.Hit       = r_hit;
    assign bus.Score     = r_score;
    assign bus.BestScore = r_best;

endmodule
